// File: rtl/edge_line_cache.sv
// Direct-mapped, multi-line read cache for the Dijkstra edge-weight matrix; fills whole lines on a miss.
// Define EDGE_LINE_CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module edge_line_cache #(
    parameter int NUM_LINES   = 4,
    parameter int LINE_WORDS  = 8,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
`ifdef EDGE_LINE_CACHE_STATS_EN
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count,
`endif
    input  logic                    clock,
    input  logic                    reset,
    input  logic [MADDR_WIDTH-1:0]  base_address,
    input  logic [INDEX_WIDTH-1:0]  number_of_nodes,
    input  logic                    flush,
    input  logic                    query_enable,
    input  logic [INDEX_WIDTH-1:0]  from_node,
    input  logic [INDEX_WIDTH-1:0]  to_node,
    output logic                    ready,
    output logic [VALUE_WIDTH-1:0]  edge_value,
    output logic [MADDR_WIDTH-1:0]  mem_addr,
    output logic                    mem_read_enable,
    input  logic [MDATA_WIDTH-1:0]  mem_read_data,
    input  logic                    mem_read_ready
);

    localparam int WW     = 2 * INDEX_WIDTH;
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int TAG_W  = WW - OFF_W;
    localparam int FULL_W = MADDR_WIDTH + WW + 32;
    localparam int BYTES  = MDATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_FILL_REQ = 3'd2,
        S_FILL_GAP = 3'd3,
        S_RESPOND  = 3'd4
    } state_t;

    // Byte address of matrix word {tag,k}, computed wide and wrapped to the bus width.
    function automatic logic [MADDR_WIDTH-1:0] word_addr(
        input logic [MADDR_WIDTH-1:0] base,
        input logic [TAG_W-1:0]       tag,
        input logic [OFF_W-1:0]       k
    );
        logic [FULL_W-1:0] word_full;
        logic [FULL_W-1:0] byte_full;
        word_full = FULL_W'({tag, k});
        byte_full = FULL_W'(base) + word_full * FULL_W'(BYTES);
        return byte_full[MADDR_WIDTH-1:0];
    endfunction

    state_t                  r_state;
    logic [INDEX_WIDTH-1:0]  r_from;
    logic [INDEX_WIDTH-1:0]  r_to;
    logic [TAG_W-1:0]        r_tag;
    logic [LINE_W-1:0]       r_line;
    logic [OFF_W-1:0]        r_off;
    logic [OFF_W-1:0]        r_k;
    logic [NUM_LINES-1:0]    r_valid;
    logic [TAG_W-1:0]        r_tags [NUM_LINES];
    logic [VALUE_WIDTH-1:0]  r_data [NUM_LINES][LINE_WORDS];
    logic                    r_poison;
    logic                    r_filled;
    logic                    r_ready;
    logic [VALUE_WIDTH-1:0]  r_edge;
    logic                    r_mem_en;
    logic [MADDR_WIDTH-1:0]  r_mem_addr;

    logic [WW-1:0]           w_word;
    logic [TAG_W-1:0]        w_tag;
    logic [OFF_W-1:0]        w_off;
    logic [LINE_W-1:0]       w_line;
    logic                    w_oor;
    logic                    w_hit;
    logic                    w_take;

    assign w_word = {{INDEX_WIDTH{1'b0}}, r_from} * {{INDEX_WIDTH{1'b0}}, number_of_nodes}
                  + {{INDEX_WIDTH{1'b0}}, r_to};
    assign w_tag  = w_word[WW-1:OFF_W];
    assign w_off  = w_word[OFF_W-1:0];
    assign w_line = LINE_W'(w_tag % TAG_W'(NUM_LINES));
    assign w_oor  = (r_from >= number_of_nodes) || (r_to >= number_of_nodes);
    assign w_hit  = r_valid[w_line] && (r_tags[w_line] == w_tag);
    assign w_take = (r_state == S_FILL_REQ) && r_mem_en && mem_read_ready;

    generate
        if (MDATA_WIDTH > VALUE_WIDTH) begin : g_upper
            logic w_unused_data;
            assign w_unused_data = ^mem_read_data[MDATA_WIDTH-1:VALUE_WIDTH];
        end
    endgenerate

`ifdef EDGE_LINE_CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

    // Line storage: captures each fill word on its memory handshake.
    always_ff @(posedge clock) begin
        if (!reset && w_take) begin
            r_data[r_line][r_k] <= mem_read_data[VALUE_WIDTH-1:0];
        end
    end

    // Control FSM, valid/tag bookkeeping and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_from     <= '0;
            r_to       <= '0;
            r_tag      <= '0;
            r_line     <= '0;
            r_off      <= '0;
            r_k        <= '0;
            r_valid    <= '0;
            r_poison   <= 1'b0;
            r_filled   <= 1'b0;
            r_ready    <= 1'b0;
            r_edge     <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
`ifdef EDGE_LINE_CACHE_STATS_EN
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
`endif
        end else begin
            r_ready <= 1'b0;
            // Flush clears everything first; state-specific writes below refine it.
            if (flush) begin
                r_valid <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (query_enable) begin
                        r_from  <= from_node;
                        r_to    <= to_node;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_tag  <= w_tag;
                    r_line <= w_line;
                    r_off  <= w_off;
                    if (w_oor) begin
                        r_edge   <= '1;
                        r_ready  <= 1'b1;
                        r_filled <= 1'b0;
                        r_state  <= S_RESPOND;
                    end else if (w_hit) begin
                        r_edge   <= r_data[w_line][w_off];
                        r_ready  <= 1'b1;
                        r_filled <= 1'b0;
                        r_state  <= S_RESPOND;
`ifdef EDGE_LINE_CACHE_STATS_EN
                        if (r_hit_count != 32'hFFFF_FFFF) begin
                            r_hit_count <= r_hit_count + 32'd1;
                        end
`endif
                    end else begin
                        r_valid[w_line] <= 1'b0;
                        r_k        <= '0;
                        r_poison   <= 1'b0;
                        r_filled   <= 1'b1;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= word_addr(base_address, w_tag, '0);
                        r_state    <= S_FILL_REQ;
`ifdef EDGE_LINE_CACHE_STATS_EN
                        if (r_miss_count != 32'hFFFF_FFFF) begin
                            r_miss_count <= r_miss_count + 32'd1;
                        end
`endif
                    end
                end
                S_FILL_REQ: begin
                    if (flush) begin
                        r_poison <= 1'b1;
                    end
                    if (mem_read_ready) begin
                        r_mem_en <= 1'b0;
                        r_state  <= S_FILL_GAP;
                    end
                end
                S_FILL_GAP: begin
                    if (flush) begin
                        r_poison <= 1'b1;
                    end
                    if (r_k == OFF_W'(LINE_WORDS - 1)) begin
                        r_edge  <= r_data[r_line][r_off];
                        r_ready <= 1'b1;
                        r_state <= S_RESPOND;
                    end else begin
                        r_k        <= r_k + OFF_W'(1'b1);
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= word_addr(base_address, r_tag, r_k + OFF_W'(1'b1));
                        r_state    <= S_FILL_REQ;
                    end
                end
                S_RESPOND: begin
                    // A flush arriving any time during the fill keeps the line invalid.
                    if (r_filled && !r_poison && !flush) begin
                        r_valid[r_line] <= 1'b1;
                        r_tags[r_line]  <= r_tag;
                    end
                    r_filled <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign ready           = r_ready;
    assign edge_value      = r_edge;
    assign mem_addr        = r_mem_addr;
    assign mem_read_enable = r_mem_en;

endmodule

// File: tb/tb_edge_line_cache.sv
// Directed self-checking bench for edge_line_cache: N=8, base 0x34, 32-bit words, word(r,c)=256r+c+1.
// Memory model answers each read in the second cycle of mem_read_enable.
module tb_edge_line_cache;

    localparam int MEM_LAT  = 2;
    localparam int MISS_LAT = 2 + 8 * (MEM_LAT + 1);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] base_address = 32'h34;
    logic [7:0]  number_of_nodes = 8'd8;
    logic        flush = 1'b0;
    logic        query_enable = 1'b0;
    logic [7:0]  from_node = 8'd0;
    logic [7:0]  to_node = 8'd0;
    logic        ready;
    logic [15:0] edge_value;
    logic [31:0] mem_addr;
    logic        mem_read_enable;
    logic [31:0] mem_read_data = 32'd0;
    logic        mem_read_ready = 1'b0;
`ifdef EDGE_LINE_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int rd_count = 0;
    int en_count = 0;
    logic [31:0] addr_log [256];

    edge_line_cache #(
        .NUM_LINES(4), .LINE_WORDS(8), .INDEX_WIDTH(8),
        .VALUE_WIDTH(16), .MADDR_WIDTH(32), .MDATA_WIDTH(32)
    ) dut (
`ifdef EDGE_LINE_CACHE_STATS_EN
        .hit_count(hit_count),
        .miss_count(miss_count),
`endif
        .clock(clock), .reset(reset), .base_address(base_address),
        .number_of_nodes(number_of_nodes), .flush(flush), .query_enable(query_enable),
        .from_node(from_node), .to_node(to_node), .ready(ready), .edge_value(edge_value),
        .mem_addr(mem_addr), .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data), .mem_read_ready(mem_read_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = (a - 32'h34) >> 2;
        return 32'd256 * (k / 32'd8) + (k % 32'd8) + 32'd1;
    endfunction

    // Memory model plus read/enable logging.
    always @(posedge clock) begin
        if (mem_read_enable) en_count <= en_count + 1;
        if (mem_read_enable && mem_read_ready) begin
            addr_log[rd_count[7:0]] <= mem_addr;
            rd_count <= rd_count + 1;
        end
        mem_read_ready <= !reset && mem_read_enable && !mem_read_ready;
        mem_read_data  <= mem_word(mem_addr);
    end

    task automatic do_query(input logic [7:0] f, input logic [7:0] t, input bit flush_third,
                            output int lat, output logic [15:0] val, output int reads,
                            output int en_cyc, output int rd0, output logic pulse_ok);
        int en0;
        bit flushed;
        rd0 = rd_count; en0 = en_count; flushed = 1'b0;
        @(negedge clock); query_enable = 1'b1; from_node = f; to_node = t;
        @(negedge clock); query_enable = 1'b0; lat = 1;
        while (ready !== 1'b1 && lat < 200) begin
            if (flush_third && !flushed && (rd_count - rd0) == 2 && mem_read_enable) begin
                flush = 1'b1; flushed = 1'b1;
            end else begin
                flush = 1'b0;
            end
            @(negedge clock); lat++;
        end
        flush = 1'b0;
        val = edge_value; reads = rd_count - rd0; en_cyc = en_count - en0;
        @(negedge clock);
        pulse_ok = (ready === 1'b0) && (edge_value === val);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_checks += 4;
        if (ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got %b want 0", ready); end
        if (mem_read_enable !== 1'b0) begin n_errors++; $display("FAIL reset_en got %b want 0", mem_read_enable); end
        if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        if (edge_value !== 16'h0) begin n_errors++; $display("FAIL reset_value got %h want 0", edge_value); end
        reset = 1'b0;
    endtask

    task automatic test_miss(input string nm, input logic [7:0] f, input logic [7:0] t,
                             input logic [31:0] first_addr, input logic [15:0] exp_val, input bit flush_third);
        int lat, reads, en_cyc, rd0, bad;
        logic [15:0] val;
        logic pulse_ok;
        do_query(f, t, flush_third, lat, val, reads, en_cyc, rd0, pulse_ok);
        n_checks += 5;
        if (val !== exp_val) begin n_errors++; $display("FAIL %s_value got %h want %h", nm, val, exp_val); end
        if (reads != 8) begin n_errors++; $display("FAIL %s_reads got %0d want 8", nm, reads); end
        if (lat != MISS_LAT) begin n_errors++; $display("FAIL %s_latency got %0d want %0d", nm, lat, MISS_LAT); end
        if (pulse_ok !== 1'b1) begin n_errors++; $display("FAIL %s_pulse got %b want 1", nm, pulse_ok); end
        bad = -1;
        for (int i = 0; i < 8; i++) begin
            if (bad < 0 && addr_log[(rd0 + i) % 256] !== first_addr + 32'(4 * i)) bad = i;
        end
        if (bad >= 0) begin
            n_errors++;
            $display("FAIL %s_addr[%0d] got %h want %h", nm, bad, addr_log[(rd0 + bad) % 256], first_addr + 32'(4 * bad));
        end
    endtask

    task automatic test_fast(input string nm, input logic [7:0] f, input logic [7:0] t, input logic [15:0] exp_val);
        int lat, reads, en_cyc, rd0;
        logic [15:0] val;
        logic pulse_ok;
        do_query(f, t, 1'b0, lat, val, reads, en_cyc, rd0, pulse_ok);
        n_checks += 4;
        if (val !== exp_val) begin n_errors++; $display("FAIL %s_value got %h want %h", nm, val, exp_val); end
        if (lat != 2) begin n_errors++; $display("FAIL %s_latency got %0d want 2", nm, lat); end
        if (en_cyc != 0) begin n_errors++; $display("FAIL %s_mem_en_cycles got %0d want 0", nm, en_cyc); end
        if (pulse_ok !== 1'b1) begin n_errors++; $display("FAIL %s_pulse got %b want 1", nm, pulse_ok); end
    endtask

    task automatic test_reset_mid_fill();
        int guard;
        @(negedge clock); query_enable = 1'b1; from_node = 8'd0; to_node = 8'd0;
        @(negedge clock); query_enable = 1'b0;
        guard = 0;
        while (mem_read_enable !== 1'b1 && guard < 20) begin @(negedge clock); guard++; end
        n_checks += 1;
        if (mem_read_enable !== 1'b1) begin n_errors++; $display("FAIL midfill_start got %b want 1", mem_read_enable); end
        reset = 1'b1;
        @(negedge clock);
        n_checks += 2;
        if (mem_read_enable !== 1'b0) begin n_errors++; $display("FAIL midfill_en got %b want 0", mem_read_enable); end
        if (ready !== 1'b0) begin n_errors++; $display("FAIL midfill_ready got %b want 0", ready); end
        reset = 1'b0;
        @(negedge clock);
        test_miss("after_reset", 8'd2, 8'd3, 32'h74, 16'h0204, 1'b0);
`ifdef EDGE_LINE_CACHE_STATS_EN
        n_checks += 2;
        if (hit_count !== 32'd0) begin n_errors++; $display("FAIL stats_hit got %0d want 0", hit_count); end
        if (miss_count !== 32'd1) begin n_errors++; $display("FAIL stats_miss got %0d want 1", miss_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_miss("cold_2_3", 8'd2, 8'd3, 32'h74, 16'h0204, 1'b0);
        test_fast("hit_2_5", 8'd2, 8'd5, 16'h0206);
        test_miss("evict_6_0", 8'd6, 8'd0, 32'hF4, 16'h0601, 1'b0);
        test_miss("remiss_2_5", 8'd2, 8'd5, 32'h74, 16'h0206, 1'b0);
        test_fast("oor_8_0", 8'd8, 8'd0, 16'hFFFF);
        test_fast("oor_0_9", 8'd0, 8'd9, 16'hFFFF);
        test_miss("flush_1_1", 8'd1, 8'd1, 32'h54, 16'h0102, 1'b1);
        test_miss("poisoned_1_2", 8'd1, 8'd2, 32'h54, 16'h0103, 1'b0);
        test_fast("hit_1_7", 8'd1, 8'd7, 16'h0108);
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
